powlib_ipram_rmw: RTL and testbench
===================================

# powlib_ipram_rmw

Bus-attached single-clock RAM slave, successor to the basic IP RAM: sits behind one write/read port pair of the bus crossbar. Adds per-byte write enables, atomic bit-set and bit-clear read-modify-write ops, configurable read latency, a buffered input, and error reporting. Read responses are posted back onto the bus to a requester-supplied return address.

## Interface
Parameters:
- B_BPD, 2, bytes per data word; B_DW = 8*B_BPD, B_BEW = B_BPD.
- B_AW, 16, address width.
- B_OPW, 4, opcode field width; bus word B_WW = B_DW+B_BEW+B_OPW, packed {op, be, data} (data at LSBs).
- B_BASE, 0, first accepted word address.
- B_SIZE, 255, last accepted offset; depth = B_SIZE+1 words, decoded range B_BASE..B_BASE+B_SIZE inclusive.
- IN_D, 8, input FIFO depth (power of two, ≥2).
- RD_LAT, 1, memory read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- wraddr  in  B_AW  request word address.
- wrdata  in  B_WW  request {op, be, data}.
- wrvld  in  1  request valid.
- wrrdy  out  1  request accepted when wrvld&wrrdy.
- rdaddr  out  B_AW  response destination (return address).
- rddata  out  B_WW  response {op=WRITE, be=all ones, data}.
- rdvld  out  1  response valid.
- rdrdy  in  1  response accepted when rdvld&rdrdy.
- err  out  1  one-cycle pulse on dropped request.

## Operation
- Opcodes: 0 WRITE, 1 READ, 2 SET, 3 CLR; all others illegal.
- Accepted requests enter the input FIFO; wrrdy = FIFO not full. Head is executed in order, one request at a time.
- Index = wraddr − B_BASE (B_AW-bit unsigned). Address outside range, or illegal op: request popped, no memory/response effect, err pulses the cycle it is popped.
- WRITE: byte k of mem[index] ← data byte k where be[k]=1; others unchanged. be=0 is a legal no-op.
- READ: data field low B_AW bits are the return address; response rdaddr=return address, rddata data=mem[index], be ignored.
- SET: mem[index] ← mem[index] | (data & bytemask(be)). CLR: mem[index] ← mem[index] & ~(data & bytemask(be)). No response.
- FSM: IDLE → (WRITE) IDLE; (READ, output slot free) RD_WAIT for RD_LAT cycles → RESP; RESP holds until rdrdy then IDLE; (SET/CLR) RMW_RD for RD_LAT cycles → RMW_WR (write back) → IDLE.
- Single output register; READ is not issued while it is occupied, so no response is lost. FIFO head waits in IDLE.
- Memory contents are not reset; reads of never-written words return X/undefined, benches pre-write before reading.

## Timing
- Reset (rst=0 at edge): rdvld=0, err=0, wrrdy=0 during reset then 1 the cycle after rst=1, FIFO empty, FSM IDLE, rdaddr/rddata=0.
- Input FIFO: request visible at head the cycle after acceptance.
- WRITE: memory updated at the edge ending its execution cycle; 1 cycle per WRITE; back-to-back WRITEs sustain 1/cycle.
- READ latency, accept to rdvld: 1 (FIFO) + RD_LAT + 1 cycles (3 at RD_LAT=1). rdvld/rdaddr/rddata stable until rdrdy.
- SET/CLR: RD_LAT+2 cycles; no other request executes meanwhile, so a following READ to the same word sees the updated value (no hazard).
- WRITE followed by READ to same word: READ returns new data.
- FIFO full and pop same cycle: wrrdy stays 0 that cycle (registered full flag); no simultaneous push/pop data corruption.
- rdrdy=0 indefinitely: FSM stays RESP; FIFO fills, wrrdy drops after IN_D further accepts.
- Reset mid-operation: in-flight RMW abandoned without write-back, pending response discarded, FIFO flushed; completed writes persist.

## Test plan
- Reset then WRITE 0x1234 be=11 at B_BASE+5, READ return 0x00A0 → rdvld with rdaddr=0x00A0, data=0x1234, 3 cycles after READ accept.
- WRITE 0xFFFF, then WRITE 0x0000 be=01, READ → data=0xFF00; SET data=0x000F be=11 → READ 0xFF0F; CLR 0xF000 → READ 0x0F0F.
- Request to B_BASE+B_SIZE+1 and opcode 7 → err pulses once each, no rdvld, memory unchanged on adjacent read.
- Hold rdrdy=0 after one READ, push IN_D+2 requests → wrrdy drops after IN_D more accepts; release rdrdy → all later requests complete in order.
- RD_LAT=2 build: READ latency 4 cycles, SET occupancy 4 cycles, data results identical to RD_LAT=1.
- Assert rst=0 during SET's RMW_RD → after reset, READ returns pre-SET value, rdvld=0 until new READ.

Source files
------------

// File: rtl/powlib_ipram_rmw_if.sv
// ---------------------------------------------------------------------------
// powlib_ipram_rmw_if
//   Bus port pair between the crossbar and the RMW RAM slave.
//   Request channel (master -> slave): wraddr, wrdata {op, be, data}, wrvld;
//     the slave returns wrrdy.
//   Response channel (slave -> master): rdaddr (return address), rddata,
//     rdvld; the master returns rdrdy.
//   err: one-cycle pulse from the slave when a request is dropped.
// ---------------------------------------------------------------------------
interface powlib_ipram_rmw_if #(
  parameter int B_AW = 16,
  parameter int B_WW = 22
);
  logic [B_AW-1:0] wraddr;
  logic [B_WW-1:0] wrdata;
  logic            wrvld;
  logic            wrrdy;
  logic [B_AW-1:0] rdaddr;
  logic [B_WW-1:0] rddata;
  logic            rdvld;
  logic            rdrdy;
  logic            err;

  modport master (
    output wraddr, wrdata, wrvld, rdrdy,
    input  wrrdy, rdaddr, rddata, rdvld, err
  );

  modport slave (
    input  wraddr, wrdata, wrvld, rdrdy,
    output wrrdy, rdaddr, rddata, rdvld, err
  );
endinterface

// File: rtl/powlib_ipram_rmw.sv
// ---------------------------------------------------------------------------
// powlib_ipram_rmw
//   Bus-attached single-clock RAM slave with per-byte write enables, atomic
//   bit-set / bit-clear read-modify-write, RD_LAT-cycle memory reads, an
//   IN_D-deep input FIFO and dropped-request error reporting.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  slave modport of powlib_ipram_rmw_if
//        wraddr/wrdata/wrvld/wrrdy : request {op, be, data}, data at LSBs
//        rdaddr/rddata/rdvld/rdrdy : read response to the return address
//        err                       : pulses the cycle a bad request is popped
//
// Opcodes: 0 WRITE, 1 READ (data[B_AW-1:0] = return address), 2 SET, 3 CLR.
// ---------------------------------------------------------------------------
module powlib_ipram_rmw #(
  parameter int B_BPD  = 2,
  parameter int B_AW   = 16,
  parameter int B_OPW  = 4,
  parameter int B_BASE = 0,
  parameter int B_SIZE = 255,
  parameter int IN_D   = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  powlib_ipram_rmw_if.slave bus
);

  localparam int B_DW    = 8 * B_BPD;
  localparam int B_BEW   = B_BPD;
  localparam int B_WW    = B_DW + B_BEW + B_OPW;
  localparam int DEPTH   = B_SIZE + 1;
  localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FIFO_AW = $clog2(IN_D);

  localparam logic [B_OPW-1:0] OP_WRITE = B_OPW'(0);
  localparam logic [B_OPW-1:0] OP_READ  = B_OPW'(1);
  localparam logic [B_OPW-1:0] OP_SET   = B_OPW'(2);
  localparam logic [B_OPW-1:0] OP_CLR   = B_OPW'(3);
  localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

  typedef struct packed {
    logic [B_AW-1:0] addr;
    logic [B_WW-1:0] word;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RESP,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  function automatic logic [B_DW-1:0] byte_mask(input logic [B_BEW-1:0] be);
    for (int k = 0; k < B_BEW; k++) byte_mask[8*k +: 8] = {8{be[k]}};
  endfunction

  // -------------------------------------------------------------------------
  // Input FIFO
  // -------------------------------------------------------------------------
  req_t               fifo_mem [IN_D];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_next;
  logic               wrrdy_q;
  logic               push;
  logic               pop;

  assign push       = bus.wrvld & wrrdy_q;
  assign count_next = count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  assign bus.wrrdy  = wrrdy_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wrrdy_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count_next;
      // Registered full flag: a pop in a full cycle frees the slot only from
      // the next cycle on, so push and pop never race on the same entry.
      wrrdy_q <= (count_next != (FIFO_AW+1)'(IN_D));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: bus.wraddr, word: bus.wrdata};
  end

  // -------------------------------------------------------------------------
  // Head decode
  // -------------------------------------------------------------------------
  req_t              head;
  logic              head_vld;
  logic [B_OPW-1:0]  head_op;
  logic [B_BEW-1:0]  head_be;
  logic [B_DW-1:0]   head_data;
  logic [B_AW-1:0]   head_off;
  logic [MEM_AW-1:0] head_idx;
  logic              head_bad;

  assign head      = fifo_mem[rd_ptr];
  assign head_vld  = (count != '0);
  assign head_op   = head.word[B_WW-1 -: B_OPW];
  assign head_be   = head.word[B_DW +: B_BEW];
  assign head_data = head.word[B_DW-1:0];
  // Unsigned offset: addresses below B_BASE wrap high and fail the range test.
  assign head_off  = head.addr - B_AW'(B_BASE);
  assign head_idx  = head_off[MEM_AW-1:0];
  assign head_bad  = (head_off > B_AW'(B_SIZE)) || (head_op > OP_CLR);

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  state_t            state;
  logic [1:0]        lat_cnt;
  logic [MEM_AW-1:0] idx_q;
  logic [B_AW-1:0]   ret_q;
  logic              is_clr_q;
  logic [B_DW-1:0]   opnd_q;
  logic              rdvld_q;
  logic [B_AW-1:0]   rdaddr_q;
  logic [B_WW-1:0]   rddata_q;

  // -------------------------------------------------------------------------
  // Memory: one write port, one registered read port addressed by idx_q
  // -------------------------------------------------------------------------
  logic [B_DW-1:0]   mem [DEPTH];
  logic [B_DW-1:0]   rd_q1;
  logic [B_DW-1:0]   rd_q2;
  logic [B_DW-1:0]   rd_word;
  logic [B_DW-1:0]   rmw_data;
  logic              wr_en;
  logic [MEM_AW-1:0] wr_idx;
  logic [B_BEW-1:0]  wr_be;
  logic [B_DW-1:0]   wr_data;
  logic              err_pulse;

  assign rd_word  = (RD_LAT == 2) ? rd_q2 : rd_q1;
  assign rmw_data = is_clr_q ? (rd_word & ~opnd_q) : (rd_word | opnd_q);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    pop       = 1'b0;
    err_pulse = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = head_idx;
    wr_be     = head_be;
    wr_data   = head_data;
    if (state == S_IDLE && head_vld) begin
      if (head_bad) begin
        pop       = 1'b1;
        err_pulse = 1'b1;
      end else if (head_op == OP_WRITE) begin
        pop   = 1'b1;
        wr_en = 1'b1;
      end else if (head_op == OP_READ) begin
        pop = !rdvld_q;                 // output slot must be free
      end else begin
        pop = 1'b1;
      end
    end else if (state == S_RMW_WR) begin
      wr_en   = 1'b1;
      wr_idx  = idx_q;
      wr_be   = '1;
      wr_data = rmw_data;
    end
  end

  // NOTE: the RAM array is deliberately not reset (contents are undefined
  // until written); only the write enable is gated so a reset abandons an
  // in-flight write-back.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int k = 0; k < B_BEW; k++) begin
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
    rd_q1 <= mem[idx_q];
    rd_q2 <= rd_q1;
  end

  // -------------------------------------------------------------------------
  // Execution FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      idx_q    <= '0;
      ret_q    <= '0;
      is_clr_q <= 1'b0;
      opnd_q   <= '0;
      rdvld_q  <= 1'b0;
      rdaddr_q <= '0;
      rddata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (head_vld && !head_bad) begin
            idx_q    <= head_idx;
            ret_q    <= B_AW'(head_data);
            is_clr_q <= (head_op == OP_CLR);
            opnd_q   <= head_data & byte_mask(head_be);
            lat_cnt  <= '0;
            if (head_op == OP_READ && !rdvld_q)                state <= S_RD_WAIT;
            else if (head_op == OP_SET || head_op == OP_CLR)   state <= S_RMW_RD;
          end
        end
        S_RD_WAIT: begin
          if (lat_cnt == LAT_LAST) state   <= S_RESP;
          else                     lat_cnt <= lat_cnt + 2'd1;
        end
        S_RESP: begin
          // First RESP cycle loads the output register; then hold until taken.
          if (!rdvld_q) begin
            rdvld_q  <= 1'b1;
            rdaddr_q <= ret_q;
            rddata_q <= {OP_WRITE, {B_BEW{1'b1}}, rd_word};
          end else if (bus.rdrdy) begin
            rdvld_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_RMW_RD: begin
          if (lat_cnt == LAT_LAST) state   <= S_RMW_WR;
          else                     lat_cnt <= lat_cnt + 2'd1;
        end
        S_RMW_WR: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdvld  = rdvld_q;
  assign bus.rdaddr = rdaddr_q;
  assign bus.rddata = rddata_q;
  assign bus.err    = rst & err_pulse;

endmodule

// File: tb/tb_powlib_ipram_rmw.sv
// ---------------------------------------------------------------------------
// tb_powlib_ipram_rmw
//   Scoreboard bench for powlib_ipram_rmw. Two instances (RD_LAT=1 and
//   RD_LAT=2) share the stimulus bus; 'sel' picks the one being exercised.
//   A reference memory per instance predicts READ results at accept time;
//   the expected response is queued and popped on each response handshake.
// ---------------------------------------------------------------------------
module tb_powlib_ipram_rmw;

  localparam int AW   = 16;
  localparam int WW   = 22;
  localparam int BASE = 0;
  localparam int SIZE = 255;
  localparam int IN_D = 8;

  localparam logic [3:0] OP_WR  = 4'd0;
  localparam logic [3:0] OP_RD  = 4'd1;
  localparam logic [3:0] OP_SET = 4'd2;
  localparam logic [3:0] OP_CLR = 4'd3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] word;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;

  logic [AW-1:0] drv_addr  = '0;
  logic [WW-1:0] drv_data  = '0;
  logic          drv_vld   = 1'b0;
  logic          drv_rdrdy = 1'b1;

  logic          mon_wrrdy;
  logic          mon_rdvld;
  logic          mon_err;
  logic [AW-1:0] mon_rdaddr;
  logic [WW-1:0] mon_rddata;

  int   checks   = 0;
  int   errors   = 0;
  int   err_seen = 0;
  int   err_exp  = 0;
  rsp_t sb [$];
  logic [15:0] model [0:1][0:255];

  always #5 clk = ~clk;

  powlib_ipram_rmw_if #(.B_AW(AW), .B_WW(WW)) bus1 ();
  powlib_ipram_rmw_if #(.B_AW(AW), .B_WW(WW)) bus2 ();

  assign bus1.wraddr = drv_addr;
  assign bus1.wrdata = drv_data;
  assign bus1.wrvld  = drv_vld & ~sel;
  assign bus1.rdrdy  = drv_rdrdy | sel;
  assign bus2.wraddr = drv_addr;
  assign bus2.wrdata = drv_data;
  assign bus2.wrvld  = drv_vld & sel;
  assign bus2.rdrdy  = drv_rdrdy | ~sel;

  assign mon_wrrdy  = sel ? bus2.wrrdy  : bus1.wrrdy;
  assign mon_rdvld  = sel ? bus2.rdvld  : bus1.rdvld;
  assign mon_err    = sel ? bus2.err    : bus1.err;
  assign mon_rdaddr = sel ? bus2.rdaddr : bus1.rdaddr;
  assign mon_rddata = sel ? bus2.rddata : bus1.rddata;

  powlib_ipram_rmw #(
    .B_BPD(2), .B_AW(AW), .B_OPW(4), .B_BASE(BASE), .B_SIZE(SIZE),
    .IN_D(IN_D), .RD_LAT(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  powlib_ipram_rmw #(
    .B_BPD(2), .B_AW(AW), .B_OPW(4), .B_BASE(BASE), .B_SIZE(SIZE),
    .IN_D(IN_D), .RD_LAT(2)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference model update for an accepted request.
  function automatic void note_accept(input logic [15:0] addr, input logic [3:0] op,
                                      input logic [1:0] be, input logic [15:0] data);
    int          s   = sel ? 1 : 0;
    logic [15:0] idx = addr - 16'(BASE);
    logic [15:0] m   = {{8{be[1]}}, {8{be[0]}}};
    if (idx > 16'(SIZE) || op > OP_CLR) begin
      err_exp++;
      return;
    end
    case (op)
      OP_WR:   model[s][idx[7:0]] = (model[s][idx[7:0]] & ~m) | (data & m);
      OP_RD:   sb.push_back('{addr: data, word: {4'h0, 2'b11, model[s][idx[7:0]]}});
      OP_SET:  model[s][idx[7:0]] = model[s][idx[7:0]] | (data & m);
      default: model[s][idx[7:0]] = model[s][idx[7:0]] & ~(data & m);
    endcase
  endfunction

  // Response monitor: compares every handshake against the scoreboard head.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      if (mon_err === 1'b1) err_seen++;
      if (mon_rdvld === 1'b1 && drv_rdrdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got addr=%h data=%h want no response",
                   mon_rdaddr, mon_rddata);
        end else begin
          e = sb.pop_front();
          if (mon_rdaddr !== e.addr || mon_rddata !== e.word) begin
            errors++;
            $display("FAIL rsp_data got addr=%h data=%h want addr=%h data=%h",
                     mon_rdaddr, mon_rddata, e.addr, e.word);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Drive one request; called and returns at posedge+#1.
  task automatic send(input logic [15:0] addr, input logic [3:0] op,
                      input logic [1:0] be, input logic [15:0] data);
    bit ok = 1'b0;
    drv_addr = addr;
    drv_data = {op, be, data};
    drv_vld  = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mon_wrrdy === 1'b1) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    drv_vld = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept addr=%h got wrrdy=0 want 1 within 200 cycles", addr);
    end else begin
      note_accept(addr, op, be, data);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Cycles from the accepting edge until rdvld is seen.
  task automatic expect_lat(input string name, input int want);
    int n = 0;
    while (mon_rdvld !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != want) begin
      errors++;
      $display("FAIL %s got %0d cycles want %0d", name, n, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if ({bus1.wrrdy, bus1.rdvld, bus1.err} !== 3'b000 || bus1.rdaddr !== '0 || bus1.rddata !== '0) begin
      errors++;
      $display("FAIL reset_lat1 got rdy/vld/err=%b%b%b addr=%h data=%h want all 0",
               bus1.wrrdy, bus1.rdvld, bus1.err, bus1.rdaddr, bus1.rddata);
    end
    if ({bus2.wrrdy, bus2.rdvld, bus2.err} !== 3'b000 || bus2.rdaddr !== '0 || bus2.rddata !== '0) begin
      errors++;
      $display("FAIL reset_lat2 got rdy/vld/err=%b%b%b addr=%h data=%h want all 0",
               bus2.wrrdy, bus2.rdvld, bus2.err, bus2.rdaddr, bus2.rddata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mon_wrrdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_early got %b want 0", mon_wrrdy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mon_wrrdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_after got %b want 1", mon_wrrdy);
    end
  endtask

  task automatic test_basic(input int lat);
    send(16'(BASE + 5), OP_WR, 2'b11, 16'h1234);
    send(16'(BASE + 5), OP_RD, 2'b00, 16'h00A0);
    expect_lat("read_latency", lat + 2);
    drain("basic");
  endtask

  task automatic test_byte_ops(input int lat);
    send(16'd10, OP_WR,  2'b11, 16'hFFFF);
    send(16'd10, OP_WR,  2'b01, 16'h0000);
    send(16'd10, OP_RD,  2'b00, 16'h0010);   // FF00
    send(16'd10, OP_SET, 2'b11, 16'h000F);
    send(16'd10, OP_RD,  2'b11, 16'h0011);   // FF0F
    send(16'd10, OP_CLR, 2'b11, 16'hF000);
    send(16'd10, OP_RD,  2'b00, 16'h0012);   // 0F0F
    send(16'd10, OP_WR,  2'b00, 16'hAAAA);   // no-op
    send(16'd10, OP_SET, 2'b10, 16'h00FF);   // masked away
    send(16'd10, OP_CLR, 2'b01, 16'hFFFF);   // clears low byte only
    send(16'd10, OP_RD,  2'b00, 16'h0013);   // 0F00
    drain("byte_ops");
    // SET occupancy: a READ queued right behind a SET waits RD_LAT+2 cycles.
    send(16'd11, OP_WR,  2'b11, 16'h1234);
    send(16'd11, OP_SET, 2'b11, 16'h0100);
    send(16'd11, OP_RD,  2'b00, 16'h0014);   // 1334
    expect_lat("set_then_read", 2 * lat + 3);
    drain("set_occupancy");
  endtask

  task automatic test_errors();
    int e0 = err_seen;
    int x0 = err_exp;
    send(16'd0,   OP_WR, 2'b11, 16'h5A5A);
    send(16'(SIZE), OP_WR, 2'b11, 16'hA5A5);
    send(16'(BASE + SIZE + 1), OP_WR, 2'b11, 16'hFFFF);  // out of range
    send(16'(SIZE), 4'd7, 2'b11, 16'h0000);              // illegal op
    send(16'(SIZE), OP_RD, 2'b00, 16'h00B0);
    send(16'd0,   OP_RD, 2'b00, 16'h00B1);
    drain("errors");
    checks++;
    if ((err_seen - e0) != 2 || (err_exp - x0) != 2) begin
      errors++;
      $display("FAIL err_pulses got %0d want %0d", err_seen - e0, err_exp - x0);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bit take;
    for (int i = 0; i < 11; i++) send(16'(20 + i), OP_WR, 2'b11, 16'h5000 + 16'(i));
    drv_rdrdy = 1'b0;
    send(16'd20, OP_RD, 2'b00, 16'h0100);
    expect_lat("bp_first_read", 3);
    for (int cyc = 0; cyc < IN_D + 6; cyc++) begin
      if (acc < IN_D + 2) begin
        drv_addr = 16'(21 + acc);
        drv_data = {OP_RD, 2'b00, 16'h0101 + 16'(acc)};
        drv_vld  = 1'b1;
      end else begin
        drv_vld = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (mon_rdvld !== 1'b1 || mon_rdaddr !== 16'h0100 || mon_rddata !== {4'h0, 2'b11, 16'h5000}) begin
        errors++;
        $display("FAIL bp_hold got vld=%b addr=%h data=%h want 1 0100 %h",
                 mon_rdvld, mon_rdaddr, mon_rddata, {4'h0, 2'b11, 16'h5000});
      end
      take = drv_vld && (mon_wrrdy === 1'b1);
      @(posedge clk);
      #1;
      if (take) begin
        note_accept(drv_addr, OP_RD, 2'b00, drv_data[15:0]);
        acc++;
      end
    end
    drv_vld = 1'b0;
    checks += 2;
    if (acc != IN_D) begin
      errors++;
      $display("FAIL bp_accepts got %0d want %0d", acc, IN_D);
    end
    if (mon_wrrdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_wrrdy got %b want 0", mon_wrrdy);
    end
    drv_rdrdy = 1'b1;
    for (int i = acc; i < IN_D + 2; i++) send(16'(21 + i), OP_RD, 2'b00, 16'h0101 + 16'(i));
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    logic [15:0] keep40;
    logic [15:0] keep41;
    send(16'd40, OP_WR, 2'b11, 16'h00F0);
    send(16'd41, OP_WR, 2'b11, 16'h1111);
    repeat (4) @(posedge clk);
    #1;
    keep40 = model[0][40];
    keep41 = model[0][41];
    send(16'd40, OP_SET, 2'b11, 16'h0F00);   // in RMW_RD at the next edge
    send(16'd41, OP_WR,  2'b11, 16'h2222);   // still queued in the FIFO
    rst = 1'b0;
    model[0][40] = keep40;
    model[0][41] = keep41;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mon_rdvld !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_rdvld got %b want 0", mon_rdvld);
      end
    end
    send(16'd40, OP_RD, 2'b00, 16'h00C0);    // 00F0, SET abandoned
    send(16'd41, OP_RD, 2'b00, 16'h00C1);    // 1111, queued WRITE flushed
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    sel = 1'b0;
    test_basic(1);
    test_byte_ops(1);
    test_errors();
    test_backpressure();
    sel = 1'b1;
    test_basic(2);
    test_byte_ops(2);
    sel = 1'b0;
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
